// File: rtl/sr_frame_arbiter.sv
// sr_frame_arbiter: arbitrates two masked-write requesters onto the parallel
// shift-register word and sequences each write against the frame cadence.
// A write is committed on the first frame after grant, then acked once the
// following frame has shifted it out. Readback is captured on every frame.
// Optional macro SR_FRAME_ARB_TIMEOUT_EN adds a cycle-count abort (err=1).
module sr_frame_arbiter #(
   parameter int               WIDTH      = 24,
   parameter logic [WIDTH-1:0] RESET_WORD = '0
`ifdef SR_FRAME_ARB_TIMEOUT_EN
   ,
   parameter int               TIMEOUT    = 4096
`endif
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             frame_done,
   input  logic [WIDTH-1:0] in_word,
   output logic [WIDTH-1:0] out_word,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [WIDTH-1:0] mask_a,
   input  logic [WIDTH-1:0] mask_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic             err,
   output logic             busy,
   output logic [WIDTH-1:0] rd_word,
   output logic             rd_valid,
   output logic             rd_changed
);

   typedef enum logic [1:0] {IDLE, PEND, SHIFT, ACK} state_t;

   state_t           state, next_state;
   logic             grant;
   logic             win_b;
   logic             grant_b;
   logic             last_b;
   logic [WIDTH-1:0] lat_data;
   logic [WIDTH-1:0] lat_mask;
   logic             timeout_hit;
   logic             err_q;
   logic             have_capture;

   // Grant decision: a single requester wins, ties go to the one not granted last.
   always_comb begin
      grant = (state == IDLE) && (req_a || req_b);
      win_b = (req_a && req_b) ? ~last_b : req_b;
   end

`ifdef SR_FRAME_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;

   // Cycles since PEND entry or the last frame; held at zero outside PEND/SHIFT.
   always_ff @(posedge CLK_IN) begin
      if (RST || state == IDLE || state == ACK || frame_done)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign timeout_hit = (state == PEND || state == SHIFT) && !frame_done &&
                        (cnt == CW'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge CLK_IN) begin
      if (RST)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (grant) next_state = PEND;
         PEND:  if (frame_done) next_state = SHIFT;
                else if (timeout_hit) next_state = ACK;
         SHIFT: if (frame_done || timeout_hit) next_state = ACK;
         ACK:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs decoded from state; err remembers whether ACK was reached by abort.
   always_comb begin
      busy  = (state != IDLE);
      ack_a = (state == ACK) && !grant_b;
      ack_b = (state == ACK) &&  grant_b;
      err   = (state == ACK) && err_q;
   end

   // Grant bookkeeping, write latching and frame-boundary commit.
   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         out_word <= RESET_WORD;
         last_b   <= 1'b1;
         grant_b  <= 1'b0;
         lat_data <= '0;
         lat_mask <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if (grant) begin
            grant_b  <= win_b;
            last_b   <= win_b;
            lat_data <= win_b ? data_b : data_a;
            lat_mask <= win_b ? mask_b : mask_a;
         end
         if (state == PEND && frame_done)
            out_word <= (out_word & ~lat_mask) | (lat_data & lat_mask);
      end
   end

   // Readback capture on every frame, with change detection after the first capture.
   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         rd_word      <= '0;
         rd_valid     <= 1'b0;
         rd_changed   <= 1'b0;
         have_capture <= 1'b0;
      end else begin
         rd_valid   <= frame_done;
         rd_changed <= frame_done && have_capture && (in_word != rd_word);
         if (frame_done) begin
            rd_word      <= in_word;
            have_capture <= 1'b1;
         end
      end
   end

endmodule
